// File: rtl/wrr_arb_pkg.sv
// Shared types and helpers for the weighted round-robin timeout arbiter.
package wrr_arb_pkg;

    localparam int TMR_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Modulo-n increment of a master index.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        if ((idx + 32'd1) >= n) begin
            return 32'd0;
        end else begin
            return idx + 32'd1;
        end
    endfunction

endpackage

// File: rtl/wrr_timeout_arbiter_rr_pick.sv
// Rotating-priority first-one finder: first set bit of req at or after ptr, mod N.
module rr_pick #(
    parameter int N  = 3,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic          found,
    output logic [SW-1:0] idx
);

    // Walk N positions starting at ptr and latch the first request hit.
    always_comb begin : scan
        int   pos;
        logic hit;
        found = 1'b0;
        idx   = {SW{1'b0}};
        pos   = 0;
        hit   = 1'b0;
        for (int k = 0; k < N; k++) begin
            pos   = (int'(ptr) + k) % N;
            hit   = req[pos] & ~found;
            idx   = hit ? SW'(pos) : idx;
            found = found | hit;
        end
    end

endmodule

// File: rtl/wrr_timeout_arbiter.sv
// Weighted round-robin arbiter for one req/ack slave, with a watchdog that
// converts a hung slave transaction into a one-cycle error pulse.
module wrr_timeout_arbiter
    import wrr_arb_pkg::*;
#(
    parameter  int N       = 3,
    parameter  int DW      = 32,
    parameter  int WW      = 4,
    parameter  int TIMEOUT = 255,
    localparam int SW      = $clog2(N)
) (
    input  logic            clk_arb,
    input  logic            rst_n,
    input  logic [N-1:0]    m_req,
    input  logic [N*DW-1:0] m_data,
    input  logic [N*WW-1:0] cfg_weight,
    output logic [N-1:0]    m_ack,
    output logic [N-1:0]    m_err,
    output logic            s_req,
    output logic [DW-1:0]   s_data,
    output logic [SW-1:0]   s_sel,
    input  logic            s_ack,
    output logic            busy
);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [WW-1:0]    WT_ZERO  = {WW{1'b0}};
    localparam logic [WW-1:0]    WT_ONE   = {{(WW-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]     ONEHOT0  = {{(N-1){1'b0}}, 1'b1};

    state_t           state_r, state_nxt;
    logic [SW-1:0]    ptr_r, ptr_nxt;
    logic [WW-1:0]    credit_r, credit_nxt;
    logic [TMR_W-1:0] tmr_r, tmr_nxt;
    logic [N-1:0]     m_ack_r, m_ack_nxt;
    logic [N-1:0]     m_err_r, m_err_nxt;
    logic             s_req_r, s_req_nxt;
    logic [DW-1:0]    s_data_r, s_data_nxt;
    logic [SW-1:0]    s_sel_r, s_sel_nxt;
    logic             busy_r, busy_nxt;

    logic [N-1:0]     elig_s;
    logic             pick_found_s;
    logic [SW-1:0]    pick_idx_s;
    logic [WW-1:0]    pick_weight_s;
    logic [DW-1:0]    pick_data_s;

    // A master with zero weight is invisible to the scan.
    always_comb begin
        elig_s = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            elig_s[i] = m_req[i] & (cfg_weight[i*WW +: WW] != WT_ZERO);
        end
    end

    rr_pick #(
        .N  (N),
        .SW (SW)
    ) u_pick (
        .req   (elig_s),
        .ptr   (ptr_r),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    // Select weight and payload of the picked master.
    always_comb begin
        pick_weight_s = WT_ZERO;
        pick_data_s   = {DW{1'b0}};
        for (int i = 0; i < N; i++) begin
            pick_weight_s = (pick_idx_s == SW'(i)) ? cfg_weight[i*WW +: WW] : pick_weight_s;
            pick_data_s   = (pick_idx_s == SW'(i)) ? m_data[i*DW +: DW]     : pick_data_s;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt  = state_r;
        ptr_nxt    = ptr_r;
        credit_nxt = credit_r;
        tmr_nxt    = tmr_r;
        m_ack_nxt  = {N{1'b0}};
        m_err_nxt  = {N{1'b0}};
        s_req_nxt  = s_req_r;
        s_data_nxt = s_data_r;
        s_sel_nxt  = s_sel_r;
        busy_nxt   = busy_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_found_s) begin
                    s_data_nxt = pick_data_s;
                    s_sel_nxt  = pick_idx_s;
                    s_req_nxt  = 1'b1;
                    busy_nxt   = 1'b1;
                    tmr_nxt    = {TMR_W{1'b0}};
                    state_nxt  = ST_WAIT;
                    // A new master (or an exhausted turn) reloads credit from the weight.
                    if ((pick_idx_s != ptr_r) || (credit_r == WT_ZERO)) begin
                        ptr_nxt    = pick_idx_s;
                        credit_nxt = pick_weight_s - WT_ONE;
                    end else begin
                        credit_nxt = credit_r - WT_ONE;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                tmr_nxt = tmr_r + TMR_W'(1);
                if (s_ack) begin
                    s_req_nxt = 1'b0;
                    busy_nxt  = 1'b0;
                    m_ack_nxt = ONEHOT0 << s_sel_r;
                    state_nxt = ST_DONE;
                end else if (tmr_r == TMR_LAST) begin
                    s_req_nxt  = 1'b0;
                    busy_nxt   = 1'b0;
                    m_err_nxt  = ONEHOT0 << s_sel_r;
                    credit_nxt = WT_ZERO;
                    state_nxt  = ST_DONE;
                end else begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_DONE: begin
                if (credit_r == WT_ZERO) begin
                    ptr_nxt = SW'(wrap_inc(32'(ptr_r), 32'(N)));
                end else begin
                    ptr_nxt = ptr_r;
                end
                state_nxt = ST_IDLE;
            end
            default: begin
                s_req_nxt = 1'b0;
                busy_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, bookkeeping and output registers.
    always_ff @(posedge clk_arb or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            ptr_r    <= {SW{1'b0}};
            credit_r <= WT_ZERO;
            tmr_r    <= {TMR_W{1'b0}};
            m_ack_r  <= {N{1'b0}};
            m_err_r  <= {N{1'b0}};
            s_req_r  <= 1'b0;
            s_data_r <= {DW{1'b0}};
            s_sel_r  <= {SW{1'b0}};
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt;
            ptr_r    <= ptr_nxt;
            credit_r <= credit_nxt;
            tmr_r    <= tmr_nxt;
            m_ack_r  <= m_ack_nxt;
            m_err_r  <= m_err_nxt;
            s_req_r  <= s_req_nxt;
            s_data_r <= s_data_nxt;
            s_sel_r  <= s_sel_nxt;
            busy_r   <= busy_nxt;
        end
    end

    assign m_ack  = m_ack_r;
    assign m_err  = m_err_r;
    assign s_req  = s_req_r;
    assign s_data = s_data_r;
    assign s_sel  = s_sel_r;
    assign busy   = busy_r;

endmodule

// File: tb/tb_wrr_timeout_arbiter.sv
// Directed bench for wrr_timeout_arbiter (N=3, TIMEOUT=8).
module tb_wrr_timeout_arbiter;

    logic        clk_arb;
    logic        rst_n;
    logic [2:0]  m_req;
    logic [95:0] m_data;
    logic [11:0] cfg_weight;
    logic [2:0]  m_ack;
    logic [2:0]  m_err;
    logic        s_req;
    logic [31:0] s_data;
    logic [1:0]  s_sel;
    logic        s_ack;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    wrr_timeout_arbiter #(
        .N       (3),
        .DW      (32),
        .WW      (4),
        .TIMEOUT (8)
    ) dut (
        .clk_arb    (clk_arb),
        .rst_n      (rst_n),
        .m_req      (m_req),
        .m_data     (m_data),
        .cfg_weight (cfg_weight),
        .m_ack      (m_ack),
        .m_err      (m_err),
        .s_req      (s_req),
        .s_data     (s_data),
        .s_sel      (s_sel),
        .s_ack      (s_ack),
        .busy       (busy)
    );

    initial clk_arb = 1'b0;
    always #5 clk_arb = ~clk_arb;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_arb);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk_arb);
        #1;
        rst_n = 1'b0;
        s_ack = 1'b0;
        m_req = 3'b000;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Called one step after a grant edge with s_ack held high; returns one step after the next grant edge.
    task automatic run_grant(input int exp_idx);
        chk("grant_req",  {31'd0, s_req}, 32'd1);
        chk("grant_sel",  {30'd0, s_sel}, 32'(exp_idx));
        chk("grant_data", s_data, m_data[exp_idx*32 +: 32]);
        chk("grant_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("ack_pulse", {29'd0, m_ack}, 32'(1 << exp_idx));
        chk("ack_noerr", {29'd0, m_err}, 32'd0);
        chk("ack_sreq",  {31'd0, s_req}, 32'd0);
        tick();
        chk("done_ack_clr", {29'd0, m_ack}, 32'd0);
        chk("done_sreq",    {31'd0, s_req}, 32'd0);
        tick();
    endtask

    initial begin
        rst_n      = 1'b0;
        m_req      = 3'b000;
        s_ack      = 1'b0;
        m_data     = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        cfg_weight = {4'd1, 4'd1, 4'd1};
        tick();
        tick();

        // Reset values
        chk("rst_sreq",  {31'd0, s_req}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_ack",   {29'd0, m_ack}, 32'd0);
        chk("rst_err",   {29'd0, m_err}, 32'd0);
        chk("rst_data",  s_data, 32'd0);
        chk("rst_sel",   {30'd0, s_sel}, 32'd0);

        // Single master, weight 1, ack two cycles after s_req
        rst_n  = 1'b1;
        m_data = {32'hCCCC_0002, 32'hA5A5_0001, 32'hAAAA_0000};
        m_req  = 3'b010;
        tick();
        chk("t1_sreq", {31'd0, s_req}, 32'd1);
        chk("t1_sel",  {30'd0, s_sel}, 32'd1);
        chk("t1_data", s_data, 32'hA5A5_0001);
        tick();
        chk("t1_wait_sreq", {31'd0, s_req}, 32'd1);
        chk("t1_wait_ack",  {29'd0, m_ack}, 32'd0);
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0;
        m_req = 3'b000;
        chk("t1_ack",  {29'd0, m_ack}, 32'd2);
        chk("t1_err",  {29'd0, m_err}, 32'd0);
        chk("t1_sreq_low", {31'd0, s_req}, 32'd0);
        chk("t1_busy_low", {31'd0, busy}, 32'd0);
        tick();
        chk("t1_ack_once",  {29'd0, m_ack}, 32'd0);
        chk("t1_data_hold", s_data, 32'hA5A5_0001);

        // Weights {2,1,3}, all requesting, slave always ready
        do_reset();
        m_data     = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        cfg_weight = {4'd3, 4'd1, 4'd2};
        m_req      = 3'b111;
        s_ack      = 1'b1;
        tick();
        run_grant(0);
        run_grant(0);
        run_grant(1);
        run_grant(2);
        run_grant(2);
        run_grant(2);
        run_grant(0);
        run_grant(0);

        // Master 1 disabled by zero weight
        do_reset();
        cfg_weight = {4'd2, 4'd0, 4'd1};
        m_req      = 3'b111;
        s_ack      = 1'b1;
        tick();
        run_grant(0);
        run_grant(2);
        run_grant(2);
        run_grant(0);
        run_grant(2);
        run_grant(2);

        // All weights zero: never grant
        do_reset();
        cfg_weight = 12'd0;
        m_req      = 3'b111;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("w0_sreq", {31'd0, s_req}, 32'd0);
            chk("w0_busy", {31'd0, busy}, 32'd0);
        end

        // Timeout: s_req held 8 cycles, error pulse, priority rotates despite credit
        do_reset();
        cfg_weight = {4'd1, 4'd1, 4'd3};
        m_req      = 3'b011;
        tick();
        chk("to_sel", {30'd0, s_sel}, 32'd0);
        chk("to_req_first", {31'd0, s_req}, 32'd1);
        for (int k = 1; k < 8; k++) begin
            tick();
            chk("to_req_held", {31'd0, s_req}, 32'd1);
            chk("to_no_err",   {29'd0, m_err}, 32'd0);
        end
        tick();
        chk("to_req_drop", {31'd0, s_req}, 32'd0);
        chk("to_err",      {29'd0, m_err}, 32'd1);
        chk("to_no_ack",   {29'd0, m_ack}, 32'd0);
        tick();
        chk("to_err_once", {29'd0, m_err}, 32'd0);
        tick();
        chk("to_rot_sel", {30'd0, s_sel}, 32'd1);
        chk("to_rot_req", {31'd0, s_req}, 32'd1);
        s_ack = 1'b1;
        tick();
        chk("to_rot_ack", {29'd0, m_ack}, 32'd2);
        s_ack = 1'b0;
        m_req = 3'b000;

        // Ack on the last timer cycle wins over timeout
        do_reset();
        cfg_weight = {4'd1, 4'd1, 4'd1};
        m_req      = 3'b001;
        tick();
        chk("race_req", {31'd0, s_req}, 32'd1);
        for (int k = 1; k < 8; k++) begin
            tick();
            chk("race_held", {31'd0, s_req}, 32'd1);
        end
        s_ack = 1'b1;
        tick();
        chk("race_ack", {29'd0, m_ack}, 32'd1);
        chk("race_err", {29'd0, m_err}, 32'd0);
        s_ack = 1'b0;
        m_req = 3'b000;
        tick();
        chk("race_err_after", {29'd0, m_err}, 32'd0);

        // Async reset during WAIT, then grant restarts from master 0
        do_reset();
        m_req = 3'b010;
        tick();
        chk("mr_sel1", {30'd0, s_sel}, 32'd1);
        m_req = 3'b011;
        tick();
        chk("mr_busy", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_sreq", {31'd0, s_req}, 32'd0);
        chk("mr_busy0", {31'd0, busy}, 32'd0);
        chk("mr_ack",  {29'd0, m_ack}, 32'd0);
        chk("mr_err",  {29'd0, m_err}, 32'd0);
        chk("mr_sel0", {30'd0, s_sel}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mr_regrant_sel", {30'd0, s_sel}, 32'd0);
        chk("mr_regrant_req", {31'd0, s_req}, 32'd1);
        s_ack = 1'b1;
        tick();
        chk("mr_regrant_ack", {29'd0, m_ack}, 32'd1);
        s_ack = 1'b0;
        m_req = 3'b000;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
